pe_credit_buf: RTL and testbench

- Credit-managed output buffer between one FFT processing element (PE) and the next stage.
- Tracks samples in flight inside the PE and holds upstream ready high while buffer space is reserved for them. This keeps the PE streaming instead of stalling until the buffer is empty.
- Supports a bypass mode: with the PE deselected, upstream data goes straight into the buffer.
- Adds an occupancy report, a sticky overflow flag and a synchronous flush.

---
 rtl/pe_credit_buf_pkg.sv | 18 +
 rtl/pe_credit_buf_if.sv | 23 ++
 rtl/pe_credit_fifo.sv | 60 ++++++
 rtl/pe_credit_buf.sv | 91 +++++++++
 tb/tb_pe_credit_buf.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_credit_buf_pkg.sv
// Shared types and helpers for the PE credit buffer.
package pe_credit_buf_pkg;

  localparam int DEFAULT_DEPTH = 8;
  localparam int SAMPLE_W      = 32;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic {
    MODE_BYPASS = 1'b0,
    MODE_PE     = 1'b1
  } mode_t;

  function automatic int clog2_plus1(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pe_credit_buf_if.sv
// Upstream, PE-return and downstream handshake bundle of the credit buffer.
interface pe_credit_buf_if #(
  parameter int WIDTH = 32
);
  logic             up_valid;
  logic [WIDTH-1:0] up_data;
  logic             ready;
  logic             pe_valid;
  logic [WIDTH-1:0] pe_data;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             next_ready;

  modport master (
    output up_valid, up_data, pe_valid, pe_data, next_ready,
    input  ready, out_valid, out_data
  );

  modport slave (
    input  up_valid, up_data, pe_valid, pe_data, next_ready,
    output ready, out_valid, out_data
  );
endinterface

// File: rtl/pe_credit_fifo.sv
// Register-array FIFO with show-ahead read and count-based full/empty.
module pe_credit_fifo
  import pe_credit_buf_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CW    = clog2_plus1(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             push_ok;
  logic             pop_ok;

  // DEPTH need not be a power of two, so wrap explicitly
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) begin
        mem[wptr] <= wdata;
        wptr      <= bump(wptr);
      end
      if (pop_ok) rptr <= bump(rptr);
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/pe_credit_buf.sv
// Credit-managed output buffer behind an FFT PE: reserves space for samples in flight.
module pe_credit_buf
  import pe_credit_buf_pkg::*;
#(
  parameter  int WIDTH  = $bits(sample_t),
  parameter  int DEPTH  = DEFAULT_DEPTH,
  parameter  int PE_LAT = 3,
  localparam int CW     = clog2_plus1(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  pe_credit_buf_if.slave    bus,
  input  logic              select,
  input  logic              flush,
  output logic [CW-1:0]     occupancy,
  output logic [CW-1:0]     inflight,
  output logic              overflow,
  output logic              idle
);
  mode_t            mode;
  logic             mode_pending;
  logic [CW:0]      used;
  logic             up_fire;
  logic             pop;
  logic             wr_req;
  logic             wr_ok;
  logic             pe_ret;
  logic             fifo_full;
  logic             fifo_empty;
  logic [WIDTH-1:0] wr_data;

  // credits come from registered counts only; a same-cycle pop is not credited
  assign used         = {1'b0, occupancy} + {1'b0, inflight};
  assign mode_pending = (select != mode);
  assign bus.ready    = (used < (CW+1)'(DEPTH)) && !mode_pending && !flush;

  assign up_fire   = bus.up_valid && bus.ready;
  assign pop       = bus.out_valid && bus.next_ready;
  assign wr_req    = (mode == MODE_PE) ? bus.pe_valid : up_fire;
  assign wr_data   = (mode == MODE_PE) ? bus.pe_data  : bus.up_data;
  assign wr_ok     = wr_req && !flush && (!fifo_full || pop);
  assign pe_ret    = (mode == MODE_PE) && bus.pe_valid && (inflight != '0);

  assign bus.out_valid = !fifo_empty;
  assign idle          = (inflight == '0) && (occupancy == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode     <= MODE_PE;
      inflight <= '0;
      overflow <= 1'b0;
    end else begin
      if (inflight == '0) mode <= mode_t'(select);
      case ({(mode == MODE_PE) && up_fire, pe_ret})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
      if (flush)                                        overflow <= 1'b0;
      else if (wr_req && fifo_full && !pop)             overflow <= 1'b1;
    end
  end

  // a PE return with nothing in flight means the PE and buffer disagree
  always_ff @(posedge clk) begin
    if (rst_n && mode == MODE_PE)
      assert (!bus.pe_valid || inflight != '0)
        else $warning("pe_credit_buf: pe_valid with no samples in flight");
    if (rst_n)
      assert (PE_LAT >= 1 && inflight <= CW'(DEPTH))
        else $error("pe_credit_buf: inflight exceeds buffer depth");
  end

  pe_credit_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (wr_ok),
    .pop   (pop && !flush),
    .wdata (wr_data),
    .rdata (bus.out_data),
    .count (occupancy),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_pe_credit_buf.sv
// Directed bench for pe_credit_buf with a fixed-latency PE model (DEPTH=4, PE_LAT=3).
module tb_pe_credit_buf;
  import pe_credit_buf_pkg::*;

  localparam int W   = 32;
  localparam int D   = 4;
  localparam int LAT = 3;
  localparam int CW  = clog2_plus1(D);

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          select = 1'b1;
  logic          flush  = 1'b0;
  logic [CW-1:0] occupancy;
  logic [CW-1:0] inflight;
  logic          overflow;
  logic          idle;

  int checks = 0;
  int errors = 0;

  pe_credit_buf_if #(.WIDTH(W)) bus ();

  pe_credit_buf #(
    .WIDTH  (W),
    .DEPTH  (D),
    .PE_LAT (LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .select    (select),
    .flush     (flush),
    .occupancy (occupancy),
    .inflight  (inflight),
    .overflow  (overflow),
    .idle      (idle)
  );

  always #5 clk = ~clk;

  // PE model: returns each accepted sample unchanged LAT cycles later
  logic [LAT-1:0] pe_v = '0;
  logic [W-1:0]   pe_d [LAT];
  logic           pe_inject = 1'b0;
  logic [W-1:0]   inj_data  = '0;
  logic [W-1:0]   seq_base  = '0;
  int             fire_cnt  = 0;
  int             cyc       = 0;
  logic [W-1:0]   rx_q [$];
  int             rx_cyc [$];
  int             tx_cyc [$];

  assign bus.up_data  = seq_base + W'(fire_cnt);
  assign bus.pe_valid = pe_v[LAT-1] || pe_inject;
  assign bus.pe_data  = pe_inject ? inj_data : pe_d[LAT-1];

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    pe_v  <= {pe_v[LAT-2:0], bus.up_valid && bus.ready};
    pe_d[0] <= bus.up_data;
    for (int i = 1; i < LAT; i++) pe_d[i] <= pe_d[i-1];
    if (bus.up_valid && bus.ready) begin
      fire_cnt <= fire_cnt + 1;
      tx_cyc.push_back(cyc);
    end
    if (bus.out_valid && bus.next_ready) begin
      rx_q.push_back(bus.out_data);
      rx_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0, rx0, tx0;
    logic       exp_rdy [4];
    logic [2:0] exp_inf [4];
    bus.up_valid   = 1'b0;
    bus.next_ready = 1'b0;
    nclk(2);

    check("rst_occ",    32'(occupancy),     0);
    check("rst_infl",   32'(inflight),      0);
    check("rst_ovf",    32'(overflow),      0);
    check("rst_ovalid", 32'(bus.out_valid), 0);
    check("rst_odata",  bus.out_data,       0);
    check("rst_idle",   32'(idle),          1);
    check("rst_ready",  32'(bus.ready),     1);
    rst_n = 1'b1;

    // fill with no downstream pop: exactly DEPTH transfers
    seq_base = 32'hA0 - 32'(fire_cnt);
    s0 = fire_cnt;
    bus.up_valid = 1'b1;
    nclk(12);
    check("fill_xfers", 32'(fire_cnt - s0), 4);
    check("fill_ready", 32'(bus.ready),     0);
    check("fill_occ",   32'(occupancy),     4);
    check("fill_infl",  32'(inflight),      0);
    check("fill_ovf",   32'(overflow),      0);
    check("fill_head",  bus.out_data,       32'hA0);
    bus.up_valid = 1'b0;

    // stray PE sample at full with no pop: dropped, sticky overflow
    pe_inject = 1'b1; inj_data = 32'hBAD;
    nclk(1);
    pe_inject = 1'b0;
    check("ovf_set", 32'(overflow),  1);
    check("ovf_occ", 32'(occupancy), 4);
    nclk(3);
    check("ovf_hold", 32'(overflow), 1);
    check("ovf_head", bus.out_data,  32'hA0);

    // write with simultaneous pop at full: accepted, occupancy unchanged
    pe_inject = 1'b1; inj_data = 32'hC1; bus.next_ready = 1'b1;
    nclk(1);
    pe_inject = 1'b0; bus.next_ready = 1'b0;
    check("fullpop_occ",  32'(occupancy), 4);
    check("fullpop_head", bus.out_data,   32'hA1);
    check("fullpop_ovf",  32'(overflow),  1);
    check("fullpop_rx",   rx_q[0],        32'hA0);

    flush = 1'b1;
    #1 check("flush_ready", 32'(bus.ready), 0);
    nclk(1);
    flush = 1'b0;
    check("flush_occ",  32'(occupancy),     0);
    check("flush_oval", 32'(bus.out_valid), 0);
    check("flush_ovf",  32'(overflow),      0);
    check("flush_idle", 32'(idle),          1);

    // streaming: 16 samples, first output 4 cycles after first transfer
    bus.next_ready = 1'b1;
    seq_base = 32'h1 - 32'(fire_cnt);
    s0  = fire_cnt;
    rx0 = rx_q.size();
    tx0 = tx_cyc.size();
    bus.up_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      nclk(1);
      if (fire_cnt - s0 >= 16) break;
    end
    bus.up_valid = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (rx_q.size() - rx0 >= 16) break;
      nclk(1);
    end
    check("strm_count", 32'(rx_q.size() - rx0), 16);
    for (int i = 0; i < 16; i++)
      if (rx0 + i < rx_q.size()) check("strm_data", rx_q[rx0+i], 32'(i + 1));
    if (rx_q.size() > rx0 && tx_cyc.size() > tx0 + 3) begin
      check("strm_latency", 32'(rx_cyc[rx0] - tx_cyc[tx0]),      4);
      check("strm_back2back", 32'(tx_cyc[tx0+3] - tx_cyc[tx0]), 3);
    end else begin
      check("strm_seen", 0, 1);
    end
    for (int k = 0; k < 20 && !idle; k++) nclk(1);
    check("strm_idle", 32'(idle), 1);

    // PE -> bypass switch with two samples in flight
    seq_base = 32'h41 - 32'(fire_cnt);
    rx0 = rx_q.size();
    bus.up_valid = 1'b1;
    nclk(2);
    check("sw_infl", 32'(inflight), 2);
    select = 1'b0;
    #1 check("sw_ready0", 32'(bus.ready), 0);
    exp_rdy = '{1'b0, 1'b0, 1'b0, 1'b1};
    exp_inf = '{3'd2, 3'd1, 3'd0, 3'd0};
    for (int i = 0; i < 4; i++) begin
      nclk(1);
      check("sw_ready", 32'(bus.ready), 32'(exp_rdy[i]));
      check("sw_drain", 32'(inflight),  32'(exp_inf[i]));
    end
    nclk(2);
    bus.up_valid = 1'b0;
    pe_inject = 1'b1; inj_data = 32'hEE;
    nclk(1);
    pe_inject = 1'b0;
    nclk(3);
    check("sw_count", 32'(rx_q.size() - rx0), 4);
    for (int i = 0; i < 4; i++)
      if (rx0 + i < rx_q.size()) check("sw_order", rx_q[rx0+i], 32'h41 + 32'(i));
    check("sw_occ",  32'(occupancy), 0);
    check("sw_infl", 32'(inflight),  0);

    // flush with occupancy=3, inflight=1; late sample still lands
    select = 1'b1;
    bus.next_ready = 1'b0;
    seq_base = 32'h61 - 32'(fire_cnt);
    nclk(1);
    bus.up_valid = 1'b1;
    nclk(3);
    bus.up_valid = 1'b0;
    nclk(1);
    bus.up_valid = 1'b1;
    #1 check("fl_ready", 32'(bus.ready), 1);
    nclk(1);
    bus.up_valid = 1'b0;
    nclk(1);
    check("fl_pre_occ",  32'(occupancy), 3);
    check("fl_pre_infl", 32'(inflight),  1);
    flush = 1'b1;
    nclk(1);
    flush = 1'b0;
    check("fl_occ",  32'(occupancy),     0);
    check("fl_oval", 32'(bus.out_valid), 0);
    check("fl_infl", 32'(inflight),      1);
    nclk(1);
    check("fl_late_occ",  32'(occupancy),     1);
    check("fl_late_oval", 32'(bus.out_valid), 1);
    check("fl_late_data", bus.out_data,       32'h64);
    check("fl_late_infl", 32'(inflight),      0);

    // asynchronous reset mid-stream with two entries held
    seq_base = 32'h71 - 32'(fire_cnt);
    bus.up_valid = 1'b1;
    nclk(1);
    bus.up_valid = 1'b0;
    nclk(3);
    check("ar_pre_occ", 32'(occupancy), 2);
    #2 rst_n = 1'b0;
    #1;
    check("ar_occ",   32'(occupancy),     0);
    check("ar_infl",  32'(inflight),      0);
    check("ar_oval",  32'(bus.out_valid), 0);
    check("ar_odata", bus.out_data,       0);
    check("ar_ovf",   32'(overflow),      0);
    check("ar_ready", 32'(bus.ready),     1);
    nclk(1);
    rst_n = 1'b1;
    nclk(1);
    check("ar_idle", 32'(idle), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
